if_prefetch: RTL

Parametrised instruction-fetch unit that replaces the bare PC register and zero-wait ROM port of the five-stage pipeline with a decoupled fetch path. It issues sequential fetch requests over a request/grant, in-order-response memory interface and buffers returned instructions in a prefetch queue. The queue feeds the IF/ID register through a valid/ready handshake. Branch redirects from decode flush the queue and discard any responses still in flight.

---
 rtl/if_prefetch_pkg.sv | 9 +
 rtl/if_prefetch_if.sv | 31 +++
 rtl/if_prefetch_sync_fifo.sv | 56 +++++
 rtl/if_prefetch.sv | 111 +++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch unit.
package if_prefetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam int          ADDR_W_DEF       = 32;
    localparam int          DATA_W_DEF       = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of redirect, memory-port and decode-handshake signals of the fetch unit.
interface if_prefetch_if #(
    parameter int ADDR_W = if_prefetch_pkg::ADDR_W_DEF,
    parameter int DATA_W = if_prefetch_pkg::DATA_W_DEF
) ();

    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_gnt;
    logic              rom_rvalid;
    logic [DATA_W-1:0] rom_rdata;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_instr;
    logic              id_ready;

    // Fetch unit side
    modport master (
        input  branch_taken, branch_addr, rom_gnt, rom_rvalid, rom_rdata, id_ready,
        output rom_req, rom_addr, if_valid, if_pc, if_instr
    );

    // Memory / decode environment side
    modport slave (
        output branch_taken, branch_addr, rom_gnt, rom_rvalid, rom_rdata, id_ready,
        input  rom_req, rom_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/if_prefetch_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop && (r_count != '0);

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates them
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_prefetch.sv
// Decoupled instruction fetch: credit-limited request issue, in-order response
// tagging with the PC, prefetch queue towards decode, and redirect flushing.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.master bus
);

    localparam int OST_W = $clog2(MAX_OUTST + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = ((CNT_W > OST_W) ? CNT_W : OST_W) + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0]        r_fpc;
    logic [ADDR_W-1:0]        r_rpc;
    logic [OST_W-1:0]         r_outst;
    logic [OST_W-1:0]         r_disc;
    logic [OST_W-1:0]         w_outst_next;
    logic [CNT_W-1:0]         w_count;
    logic                     w_empty;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [SUM_W-1:0]         w_inflight;
    logic [ADDR_W-1:0]        w_target;
    logic                     w_req;
    logic                     w_grant;
    logic                     w_resp;
    logic                     w_push;
    logic                     w_valid;
    logic                     w_pop;
    logic                     w_unused_lsb;

    assign w_target     = {bus.branch_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_lsb = ^bus.branch_addr[1:0];

    // Credit rule: every granted request already owns a queue slot for its response
    assign w_inflight = SUM_W'(w_count) + SUM_W'(r_outst);
    assign w_req      = rst && (r_outst < OST_W'(MAX_OUTST)) && (w_inflight < SUM_W'(DEPTH));
    assign w_grant    = w_req && bus.rom_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored
    assign w_resp     = bus.rom_rvalid && (r_outst != '0);
    assign w_push     = w_resp && (r_disc == '0) && !bus.branch_taken;
    assign w_valid    = rst && !w_empty && !bus.branch_taken;
    assign w_pop      = w_valid && bus.id_ready;

    // Requests in flight after this edge, also the stale-drop count on redirect
    always_comb begin
        w_outst_next = r_outst;
        case ({w_grant, w_resp})
            2'b10:   w_outst_next = r_outst + OST_W'(1);
            2'b01:   w_outst_next = r_outst - OST_W'(1);
            default: w_outst_next = r_outst;
        endcase
    end

    // Outstanding-request counter
    always_ff @(posedge clk) begin
        if (!rst) r_outst <= '0;
        else      r_outst <= w_outst_next;
    end

    // Fetch address: advances on grant, reloaded on redirect (redirect wins)
    always_ff @(posedge clk) begin
        if (!rst)                  r_fpc <= RESET_PC;
        else if (bus.branch_taken) r_fpc <= w_target;
        else if (w_grant)          r_fpc <= r_fpc + STEP;
    end

    // Response tagging PC and stale-response discard count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rpc  <= RESET_PC;
            r_disc <= '0;
        end else if (bus.branch_taken) begin
            r_rpc  <= w_target;
            r_disc <= w_outst_next;
        end else if (w_resp) begin
            if (r_disc != '0) r_disc <= r_disc - OST_W'(1);
            else              r_rpc  <= r_rpc + STEP;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_rpc, bus.rom_rdata}),
        .i_pop   (w_pop),
        .i_flush (bus.branch_taken),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign bus.rom_req  = w_req;
    assign bus.rom_addr = r_fpc;
    assign bus.if_valid = w_valid;
    assign bus.if_pc    = (rst && !w_empty) ? w_head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign bus.if_instr = (rst && !w_empty) ? w_head[DATA_W-1:0] : '0;

endmodule
